// File: rtl/rounding_pkg.sv
// Shared types and constants for the iterative floating-point units.
// Holds the rounding-mode encoding, the common FSM states and the exponent bias.
package rounding_pkg;

  typedef enum logic [2:0] {
    IEEE_near = 3'd0,
    IEEE_zero = 3'd1,
    IEEE_pinf = 3'd2,
    IEEE_ninf = 3'd3,
    near_up   = 3'd4,
    away_zero = 3'd5
  } round_mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } fsm_state_e;

  localparam int unsigned BIAS = 127;

  // Input bundle of the downstream exception stage.
  typedef struct packed {
    logic [31:0] z_calc;
    logic        overflow;
    logic        underflow;
    logic        inexact;
    logic [2:0]  round_mode;
  } exc_in_t;

endpackage

// File: rtl/round_inc.sv
// Rounding increment decision from lsb, round bit, sticky bit and sign.
// Codes outside the defined rounding modes behave as round-to-nearest-even.
module round_inc
  import rounding_pkg::*;
(
  input  logic       l_bit,
  input  logic       r_bit,
  input  logic       s_bit,
  input  logic       sign,
  input  logic [2:0] round_mode,
  output logic       inc
);

  always_comb begin
    inc = 1'b0;
    case (round_mode)
      IEEE_zero: inc = 1'b0;
      IEEE_pinf: inc = !sign & (r_bit | s_bit);
      IEEE_ninf: inc = sign & (r_bit | s_bit);
      near_up:   inc = r_bit & (s_bit | !sign);
      away_zero: inc = r_bit | s_bit;
      default:   inc = r_bit & (s_bit | l_bit);
    endcase
  end

endmodule

// File: rtl/fp_mult_iter.sv
// Iterative single-precision multiplier: radix-2 shift-add over 24 cycles, then normalise
// and round. Produces the raw packed product and flags; special operands are handled downstream.
module fp_mult_iter
  import rounding_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  round_mode,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] z_calc,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic [2:0]  round_mode_out,
  output logic        out_valid,
  input  logic        out_ready
);

  fsm_state_e state;
  logic [4:0]        cnt;
  logic [47:0]       p;
  logic [47:0]       mcand;
  logic [23:0]       mplier;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [2:0]        rm_q;
  logic [23:0]       mant_q;
  logic              rbit_q;
  logic              sticky_q;

  logic              inc;
  logic [24:0]       mant_sum;
  logic signed [9:0] exp_rnd;
  logic              unused_hidden;

  round_inc u_round_inc (
    .l_bit      (mant_q[0]),
    .r_bit      (rbit_q),
    .s_bit      (sticky_q),
    .sign       (sign_q),
    .round_mode (rm_q),
    .inc        (inc)
  );

  // A carry out of the 24-bit mantissa leaves the fraction bits all zero, i.e. 1.000..0.
  always_comb begin
    mant_sum = {1'b0, mant_q} + {24'd0, inc};
    exp_rnd  = mant_sum[24] ? exp_q + 10'sd1 : exp_q;
  end

  assign unused_hidden = mant_sum[23];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 5'd0;
      p              <= 48'd0;
      mcand          <= 48'd0;
      mplier         <= 24'd0;
      sign_q         <= 1'b0;
      exp_q          <= 10'sd0;
      rm_q           <= 3'd0;
      mant_q         <= 24'd0;
      rbit_q         <= 1'b0;
      sticky_q       <= 1'b0;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      z_calc         <= 32'd0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
      inexact        <= 1'b0;
      round_mode_out <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= a[31] ^ b[31];
            exp_q    <= 10'({2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'(BIAS));
            mcand    <= {24'd0, 1'b1, a[22:0]};
            mplier   <= {1'b1, b[22:0]};
            rm_q     <= round_mode;
            p        <= 48'd0;
            cnt      <= 5'd0;
            in_ready <= 1'b0;
            state    <= MULT;
          end
        end
        MULT: begin
          if (mplier[0]) begin
            p <= p + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == 5'd23) begin
            cnt   <= 5'd0;
            state <= NORM;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        NORM: begin
          if (p[47]) begin
            mant_q   <= p[47:24];
            rbit_q   <= p[23];
            sticky_q <= |p[22:0];
            exp_q    <= exp_q + 10'sd1;
          end else begin
            mant_q   <= p[46:23];
            rbit_q   <= p[22];
            sticky_q <= |p[21:0];
          end
          state <= ROUND;
        end
        ROUND: begin
          z_calc         <= {sign_q, exp_rnd[7:0], mant_sum[22:0]};
          overflow       <= exp_rnd >= 10'sd255;
          underflow      <= exp_rnd <= 10'sd0;
          inexact        <= rbit_q | sticky_q;
          round_mode_out <= rm_q;
          out_valid      <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_iter.sv
// Directed and random bench for fp_mult_iter with a reference model and result scoreboard.
module tb_fp_mult_iter;
  import rounding_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [2:0]  round_mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] z_calc;
  logic        overflow, underflow, inexact;
  logic [2:0]  round_mode_out;
  logic        out_valid;
  logic        out_ready;

  typedef struct packed {
    logic [31:0] z;
    logic [2:0]  flags;
    logic [2:0]  rm;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_z;
  logic [2:0]  last_f;

  always #5 clk = ~clk;

  fp_mult_iter dut (
    .clk            (clk),
    .rst            (rst),
    .a              (a),
    .b              (b),
    .round_mode     (round_mode),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .z_calc         (z_calc),
    .overflow       (overflow),
    .underflow      (underflow),
    .inexact        (inexact),
    .round_mode_out (round_mode_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [2:0] rm);
    logic [47:0] pp;
    logic [23:0] m;
    logic        r, s, sg, inc;
    int          e;
    exp_t        res;
    pp = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e  = int'(x[30:23]) + int'(y[30:23]) - 127;
    sg = x[31] ^ y[31];
    if (pp[47]) begin
      m = pp[47:24]; r = pp[23]; s = |pp[22:0]; e = e + 1;
    end else begin
      m = pp[46:23]; r = pp[22]; s = |pp[21:0];
    end
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = !sg & (r | s);
      3'd3:    inc = sg & (r | s);
      3'd4:    inc = r & (s | !sg);
      3'd5:    inc = r | s;
      default: inc = r & (s | m[0]);
    endcase
    if (inc) begin
      if (m == 24'hFFFFFF) begin
        m = 24'h800000;
        e = e + 1;
      end else begin
        m = m + 24'd1;
      end
    end
    res.z     = {sg, e[7:0], m[22:0]};
    res.flags = {e >= 255, e <= 0, r | s};
    res.rm    = rm;
    return res;
  endfunction

  // Called #1 after a rising edge; the following edge accepts the operands.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a          = x;
    b          = y;
    round_mode = rm;
    in_valid   = 1'b1;
    sb_q.push_back(model(x, y, rm));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd26);
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check({tag, "_unexpected_output"}, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({tag, "_z"}, z_calc, e.z);
        check({tag, "_flags"}, 32'({overflow, underflow, inexact}), 32'(e.flags));
        check({tag, "_rm"}, 32'(round_mode_out), 32'(e.rm));
      end
      last_z = z_calc;
      last_f = {overflow, underflow, inexact};
      for (int i = 0; i < hold; i++) begin
        a        = 32'h40490FDB;
        b        = 32'h3F000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_hold_z"}, z_calc, last_z);
        check({tag, "_hold_flags"}, 32'({overflow, underflow, inexact}), 32'(last_f));
        check({tag, "_hold_valid"}, 32'({out_valid, in_ready}), 32'b10);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_release"}, 32'({out_valid, in_ready}), 32'b01);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    a          = 32'd0;
    b          = 32'd0;
    round_mode = 3'd0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_z", z_calc, 32'd0);
    check("reset_flags", 32'({overflow, underflow, inexact}), 32'd0);
    check("reset_hs", 32'({out_valid, in_ready}), 32'b01);
    rst = 1'b0;

    // First acceptance on the edge right after reset release.
    start_op(32'h3FC00000, 32'h40000000, IEEE_near);
    finish_op("basic", 0);
    check("basic_const", last_z, 32'h40400000);
    check("basic_const_flags", 32'(last_f), 32'b000);

    start_op(32'h3F800001, 32'h3F800001, IEEE_near);
    finish_op("near", 0);
    check("near_const", last_z, 32'h3F800002);
    check("near_inexact", 32'(last_f[0]), 32'd1);

    start_op(32'h3F800001, 32'h3F800001, IEEE_pinf);
    finish_op("pinf_hold", 10);
    check("pinf_const", last_z, 32'h3F800003);

    start_op(32'h7F000000, 32'h7F000000, IEEE_near);
    finish_op("ovf", 0);
    check("ovf_flags", 32'(last_f[2:1]), 32'b10);

    start_op(32'h00800000, 32'h00800000, IEEE_near);
    finish_op("unf", 0);
    check("unf_flags", 32'(last_f[2:1]), 32'b01);

    // Mantissa rounds up to 10.000..0 and bumps the exponent.
    start_op(32'h3FB504F3, 32'h3FB504F3, away_zero);
    finish_op("carry", 0);
    check("carry_const", last_z, 32'h40000000);

    // out_ready held high throughout: no effect before DONE.
    out_ready = 1'b1;
    start_op(32'hC0400000, 32'h3F400000, near_up);
    finish_op("rdy_early", 0);

    // Reset during MULT iteration 12 aborts the operation.
    start_op(32'h40A00000, 32'h40E00000, IEEE_near);
    repeat (12) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_z", z_calc, 32'd0);
    check("abort_flags", 32'({overflow, underflow, inexact}), 32'd0);
    check("abort_hs", 32'({out_valid, in_ready}), 32'b01);
    void'(sb_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_op(32'h40A00000, 32'h40E00000, IEEE_near);
    finish_op("after_abort", 0);
    check("after_abort_const", last_z, 32'h420C0000);

    for (int i = 0; i < 6; i++) begin
      start_op($urandom, $urandom, 3'($urandom_range(0, 7)));
      finish_op("rnd", 0);
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
